// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arb_owner_e records which port owns the read data that returns
// one cycle after a grant. IF_FETCH_BE is the all-ones fetch byte-enable
// source, sliced to DW/8 by the user.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } arb_owner_e;

  // Wide enough for any DW up to 512; users take the low DW/8 bits.
  localparam logic [63:0] IF_FETCH_BE = '1;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
// Latency: at_max_o reflects the registered count, updated on each rising edge.
// Backpressure: none; inc_i is ignored once the count sits at MAX.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   inc_i      count one more data grant won over a waiting fetch
//   clr_i      fetch was served or stopped asking; restart the streak
//   at_max_o   streak has reached MAX, fetch must win the next contention
module arb_streak_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign at_max_o = (r_cnt == W'(MAX));

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port sync RAM between the fetch port and the load/store port.
// Latency: grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: the losing requester sees stall_*_o and must hold its request.
// Optional feature macro: ARB_ANTI_STARVE_EN (fetch wins after MAX_D_STREAK data wins).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req_i/if_addr_i          fetch request;  if_gnt_o, if_rvalid_o, if_rdata_o back
//   d_req_i/d_we_i/d_be_i/...   load/store request; d_gnt_o, d_rvalid_o, d_rdata_o back
//   mem_*_o / mem_rdata_i       RAM command and read data
//   stall_if_o, stall_d_o       request pending but not granted this cycle
module imem_dmem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [DW-1:0]   d_rdata_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            stall_if_o,
  output logic            stall_d_o
);

  if (MAX_D_STREAK < 1) begin : g_bad_streak
    $error("MAX_D_STREAK must be at least 1");
  end

  arb_owner_e     r_owner;
  logic [DW-1:0]  r_if_rdata;
  logic [DW-1:0]  r_d_rdata;
  logic           w_starve;
  logic           w_if_gnt;
  logic           w_d_gnt;

`ifdef ARB_ANTI_STARVE_EN
  logic w_streak_inc;
  logic w_streak_clr;

  // Only data wins taken against a waiting fetch count toward the streak.
  assign w_streak_inc = w_d_gnt & if_req_i;
  assign w_streak_clr = w_if_gnt | ~if_req_i;

  arb_streak_counter #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (w_streak_inc),
    .clr_i    (w_streak_clr),
    .at_max_o (w_starve)
  );
`else
  assign w_starve = 1'b0;
`endif

  // Data normally wins so the older instruction drains first; a starved
  // fetch overrides that only while it is actually contending.
  assign w_d_gnt  = d_req_i & ~(if_req_i & w_starve);
  assign w_if_gnt = if_req_i & ~w_d_gnt;

  assign if_gnt_o   = w_if_gnt;
  assign d_gnt_o    = w_d_gnt;
  assign stall_if_o = if_req_i & ~w_if_gnt;
  assign stall_d_o  = d_req_i & ~w_d_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_d_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (w_if_gnt) begin
      mem_en_o    = 1'b1;
      mem_be_o    = IF_FETCH_BE[DW/8-1:0];
      mem_addr_o  = if_addr_i;
    end
  end

  // Owner of the RAM data arriving next cycle. Stores complete at grant,
  // so they leave no owner behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= RESP_NONE;
    end else if (w_if_gnt) begin
      r_owner <= RESP_IF;
    end else if (w_d_gnt && !d_we_i) begin
      r_owner <= RESP_D;
    end else begin
      r_owner <= RESP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (r_owner == RESP_IF) r_if_rdata <= mem_rdata_i;
      if (r_owner == RESP_D)  r_d_rdata  <= mem_rdata_i;
    end
  end

  // Reset in the response cycle drops the in-flight result.
  assign if_rvalid_o = (r_owner == RESP_IF) & ~rst;
  assign d_rvalid_o  = (r_owner == RESP_D)  & ~rst;

  // Bypass the RAM data in the rvalid cycle, then hold it.
  assign if_rdata_o = if_rvalid_o ? mem_rdata_i : r_if_rdata;
  assign d_rdata_o  = d_rvalid_o  ? mem_rdata_i : r_d_rdata;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: behavioural RAM, reference model and
// directed plus random stimulus. Builds with or without ARB_ANTI_STARVE_EN.
module tb_imem_dmem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i;
  logic [BW-1:0] d_be_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_if_o, stall_d_o;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter #(
    .AW (AW), .DW (DW), .MAX_D_STREAK (MAXS)
  ) dut (
    .clk (clk), .rst (rst),
    .if_req_i (if_req_i), .if_addr_i (if_addr_i), .if_gnt_o (if_gnt_o),
    .if_rvalid_o (if_rvalid_o), .if_rdata_o (if_rdata_o),
    .d_req_i (d_req_i), .d_we_i (d_we_i), .d_be_i (d_be_i), .d_addr_i (d_addr_i),
    .d_wdata_i (d_wdata_i), .d_gnt_o (d_gnt_o), .d_rvalid_o (d_rvalid_o),
    .d_rdata_o (d_rdata_o),
    .mem_en_o (mem_en_o), .mem_we_o (mem_we_o), .mem_be_o (mem_be_o),
    .mem_addr_o (mem_addr_o), .mem_wdata_o (mem_wdata_o), .mem_rdata_i (mem_rdata_i),
    .stall_if_o (stall_if_o), .stall_d_o (stall_d_o)
  );

  // Behavioural single-port RAM, 256 words, driven by the DUT's RAM port.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  assign mem_rdata_i = ram_q;

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) ram[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        ram_q <= ram[mem_addr_o[9:2]];
      end
    end
  end

  // Reference model: which port expects data next cycle and with what value,
  // held read data per port, a shadow of memory contents, and the streak.
  int            m_resp;      // 0 none, 1 fetch, 2 data
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_held_if, m_held_d;
  int            m_streak;
  logic [DW-1:0] shadow [256];

  int n_chk  = 0;
  int n_pass = 0;

  logic          s_if_gnt, s_d_gnt, s_if_rv, s_d_rv, s_stall_if;
  logic          s_mem_we;
  logic [BW-1:0] s_mem_be;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_if_rd, s_d_rd, s_mem_wdata;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic logic [AW-1:0] waddr(int idx);
    return AW'(idx * 4);
  endfunction

  task automatic idle_inputs();
    if_req_i  = 1'b0; if_addr_i = '0;
    d_req_i   = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
  endtask

  // One clock: check all outputs at the falling edge, then advance the model.
  task automatic step();
    logic          starve, e_dg, e_ig, e_ifrv, e_drv;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
`ifdef ARB_ANTI_STARVE_EN
    starve = (m_streak == MAXS);
`else
    starve = 1'b0;
`endif
    // Data wins any contention unless fetch has waited out a full streak.
    e_dg   = d_req_i && !(if_req_i && starve);
    e_ig   = if_req_i && !e_dg;
    e_ifrv = !rst && (m_resp == 1);
    e_drv  = !rst && (m_resp == 2);
    e_be   = e_dg ? d_be_i : (e_ig ? {BW{1'b1}} : '0);
    e_addr = e_dg ? d_addr_i : (e_ig ? if_addr_i : '0);
    e_wd   = e_dg ? d_wdata_i : '0;

    chk("if_gnt",    64'(if_gnt_o),    64'(e_ig));
    chk("d_gnt",     64'(d_gnt_o),     64'(e_dg));
    chk("stall_if",  64'(stall_if_o),  64'(if_req_i && !e_ig));
    chk("stall_d",   64'(stall_d_o),   64'(d_req_i && !e_dg));
    chk("mem_en",    64'(mem_en_o),    64'(e_dg || e_ig));
    chk("mem_we",    64'(mem_we_o),    64'(e_dg && d_we_i));
    chk("mem_be",    64'(mem_be_o),    64'(e_be));
    chk("mem_addr",  64'(mem_addr_o),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata_o), 64'(e_wd));
    chk("if_rvalid", 64'(if_rvalid_o), 64'(e_ifrv));
    chk("d_rvalid",  64'(d_rvalid_o),  64'(e_drv));
    chk("if_rdata",  64'(if_rdata_o),  64'(e_ifrv ? m_rdata : m_held_if));
    chk("d_rdata",   64'(d_rdata_o),   64'(e_drv ? m_rdata : m_held_d));

    s_if_gnt = if_gnt_o; s_d_gnt = d_gnt_o; s_if_rv = if_rvalid_o; s_d_rv = d_rvalid_o;
    s_stall_if = stall_if_o; s_if_rd = if_rdata_o; s_d_rd = d_rdata_o;
    s_mem_we = mem_we_o; s_mem_be = mem_be_o; s_mem_addr = mem_addr_o; s_mem_wdata = mem_wdata_o;

    @(posedge clk);
    if (m_resp == 1) m_held_if = m_rdata;
    if (m_resp == 2) m_held_d  = m_rdata;
    if (e_dg && d_we_i)
      for (int b = 0; b < BW; b++)
        if (d_be_i[b]) shadow[d_addr_i[9:2]][b*8 +: 8] = d_wdata_i[b*8 +: 8];
    if (e_ig) begin
      m_resp = 1; m_rdata = shadow[if_addr_i[9:2]];
    end else if (e_dg && !d_we_i) begin
      m_resp = 2; m_rdata = shadow[d_addr_i[9:2]];
    end else begin
      m_resp = 0;
    end
    if (e_ig || !if_req_i) m_streak = 0;
    else if (e_dg && m_streak < MAXS) m_streak++;
    if (rst) begin
      m_resp = 0; m_held_if = '0; m_held_d = '0; m_streak = 0;
    end
    #1;
  endtask

  logic [19:0] gpat;
  logic [19:0] gpat_exp;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'h13 + 32'h80 * i;
      shadow[i] = 32'h13 + 32'h80 * i;
    end
    ram_q = '0;
    m_resp = 0; m_rdata = '0; m_held_if = '0; m_held_d = '0; m_streak = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    chk("rst_mem_en", 64'(mem_en_o), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_if_rdata", 64'(s_if_rd), 64'd0);
    chk("rst_d_rdata",  64'(s_d_rd),  64'd0);

    // Fetch stream on consecutive cycles.
    if_req_i = 1'b1; if_addr_i = 32'h0; step();
    chk("s1_gnt0", 64'(s_if_gnt), 64'd1);
    chk("s1_stall0", 64'(s_stall_if), 64'd0);
    if_addr_i = 32'h4; step();
    chk("s1_rv0", 64'(s_if_rv), 64'd1);
    chk("s1_rd0", 64'(s_if_rd), 64'h13);
    if_addr_i = 32'h8; step();
    chk("s1_rd1", 64'(s_if_rd), 64'h93);
    idle_inputs(); step();
    chk("s1_rd2", 64'(s_if_rd), 64'h113);
    step();
    chk("s1_rv_end", 64'(s_if_rv), 64'd0);
    chk("s1_hold", 64'(s_if_rd), 64'h113);

    // Load and fetch together: load first, fetch next cycle.
    d_req_i = 1'b1; d_addr_i = 32'h100; if_req_i = 1'b1; if_addr_i = 32'h10; step();
    chk("s2_dgnt", 64'(s_d_gnt), 64'd1);
    chk("s2_stall_if", 64'(s_stall_if), 64'd1);
    d_req_i = 1'b0; step();
    chk("s2_drv", 64'(s_d_rv), 64'd1);
    chk("s2_drd", 64'(s_d_rd), 64'h2013);
    chk("s2_ifgnt", 64'(s_if_gnt), 64'd1);
    idle_inputs(); step();
    chk("s2_ifrd", 64'(s_if_rd), 64'h213);

    // Partial store, then read it back.
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h200; d_wdata_i = 32'hDEADBEEF;
    step();
    chk("s3_we", 64'(s_mem_we), 64'd1);
    chk("s3_be", 64'(s_mem_be), 64'h3);
    chk("s3_addr", 64'(s_mem_addr), 64'h200);
    chk("s3_wdata", 64'(s_mem_wdata), 64'hDEADBEEF);
    idle_inputs(); step();
    chk("s3_no_rv", 64'(s_d_rv), 64'd0);
    d_req_i = 1'b1; d_addr_i = 32'h200; step();
    idle_inputs(); step();
    chk("s3_readback", 64'(s_d_rd), 64'h0000BEEF);

    // Reset lands on the response cycle of a load.
    d_req_i = 1'b1; d_addr_i = 32'h104; step();
    idle_inputs(); rst = 1'b1; step();
    chk("s4_rv_drop", 64'(s_d_rv), 64'd0);
    rst = 1'b0; step();
    chk("s4_d_rd0", 64'(s_d_rd), 64'd0);
    chk("s4_if_rd0", 64'(s_if_rd), 64'd0);
    d_req_i = 1'b1; d_addr_i = 32'h108; step();
    idle_inputs(); step();
    chk("s4_rv", 64'(s_d_rv), 64'd1);
    chk("s4_rd", 64'(s_d_rd), 64'h2113);

    // Both ports held busy for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      if_req_i = 1'b1; if_addr_i = waddr($urandom_range(0, 255));
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = waddr($urandom_range(0, 255));
      step();
      gpat[k] = s_if_gnt;
    end
`ifdef ARB_ANTI_STARVE_EN
    gpat_exp = 20'h84210;
`else
    gpat_exp = 20'h00000;
`endif
    chk("s5_fetch_pattern", 64'(gpat), 64'(gpat_exp));
    idle_inputs(); step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      if_req_i  = ($urandom_range(0, 2) != 0);
      if_addr_i = waddr($urandom_range(0, 255));
      d_req_i   = ($urandom_range(0, 2) != 0);
      d_we_i    = ($urandom_range(0, 2) == 0);
      d_be_i    = BW'($urandom_range(0, 15));
      d_addr_i  = waddr($urandom_range(0, 255));
      d_wdata_i = $urandom;
      step();
    end
    rst = 1'b0; idle_inputs(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
